// File: rtl/nand_bus_sequencer.sv
// Per-port NAND flash bus timing engine: turns single CMD/ADDR/WRITE/READ/WAIT_RB
// requests into timed CLE/ALE/WEN/REN/IO waveforms and reports completion.
module nand_bus_sequencer #(
  parameter int T_SETUP = 1,
  parameter int T_PULSE = 2,
  parameter int T_HOLD  = 1,
  parameter int T_WB    = 2,
  parameter int TIMEOUT = 1023
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       req_valid,
  output logic       req_ready,
  input  logic [2:0] req_op,
  input  logic [7:0] req_data,
  output logic       rsp_valid,
  output logic [7:0] rsp_data,
  output logic       rsp_err,
  output logic       F_CLE,
  output logic       F_ALE,
  output logic       F_WEN,
  output logic       F_REN,
  input  logic       F_RB,
  output logic [7:0] F_IO_out,
  output logic       F_IO_oe,
  input  logic [7:0] F_IO_in
);

  localparam logic [2:0] ST_IDLE   = 3'd0;
  localparam logic [2:0] ST_SETUP  = 3'd1;
  localparam logic [2:0] ST_PULSE  = 3'd2;
  localparam logic [2:0] ST_HOLD   = 3'd3;
  localparam logic [2:0] ST_WB     = 3'd4;
  localparam logic [2:0] ST_WAITRB = 3'd5;

  localparam logic [2:0] OP_CMD    = 3'd0;
  localparam logic [2:0] OP_ADDR   = 3'd1;
  localparam logic [2:0] OP_WRITE  = 3'd2;
  localparam logic [2:0] OP_READ   = 3'd3;
  localparam logic [2:0] OP_WAITRB = 3'd4;

  localparam logic [3:0]  SETUP_LOAD = 4'(T_SETUP - 1);
  localparam logic [3:0]  PULSE_LOAD = 4'(T_PULSE - 1);
  localparam logic [3:0]  HOLD_LOAD  = 4'(T_HOLD - 1);
  localparam logic [3:0]  WB_LOAD    = 4'(T_WB - 1);
  localparam logic [15:0] WAIT_LOAD  = 16'(TIMEOUT - 1);

  logic [2:0]  state_reg, state_next;
  logic [2:0]  op_reg, op_next;
  logic [7:0]  data_reg, data_next;
  logic [3:0]  phase_cnt_reg, phase_cnt_next;
  logic [15:0] wait_cnt_reg, wait_cnt_next;
  logic        rsp_valid_reg, rsp_valid_next;
  logic        rsp_err_reg, rsp_err_next;
  logic [7:0]  rsp_data_reg, rsp_data_next;

  always_comb begin
    state_next     = state_reg;
    op_next        = op_reg;
    data_next      = data_reg;
    phase_cnt_next = phase_cnt_reg;
    wait_cnt_next  = wait_cnt_reg;
    rsp_valid_next = 1'b0;
    rsp_err_next   = 1'b0;
    rsp_data_next  = rsp_data_reg;
    case (state_reg)
      ST_IDLE: begin
        if (req_valid) begin
          op_next   = req_op;
          data_next = req_data;
          case (req_op)
            OP_CMD, OP_ADDR, OP_WRITE, OP_READ: begin
              state_next     = ST_SETUP;
              phase_cnt_next = SETUP_LOAD;
            end
            OP_WAITRB: begin
              state_next     = ST_WB;
              phase_cnt_next = WB_LOAD;
            end
            default: begin
              // Illegal op: no bus activity, error reported next cycle.
              rsp_valid_next = 1'b1;
              rsp_err_next   = 1'b1;
            end
          endcase
        end
      end
      ST_SETUP: begin
        if (phase_cnt_reg == 4'd0) begin
          state_next     = ST_PULSE;
          phase_cnt_next = PULSE_LOAD;
        end else begin
          phase_cnt_next = phase_cnt_reg - 4'd1;
        end
      end
      ST_PULSE: begin
        if (phase_cnt_reg == 4'd0) begin
          state_next     = ST_HOLD;
          phase_cnt_next = HOLD_LOAD;
          // Sample the flash byte while REN is still low.
          if (op_reg == OP_READ) rsp_data_next = F_IO_in;
        end else begin
          phase_cnt_next = phase_cnt_reg - 4'd1;
        end
      end
      ST_HOLD: begin
        if (phase_cnt_reg == 4'd0) begin
          state_next     = ST_IDLE;
          rsp_valid_next = (op_reg == OP_READ);
        end else begin
          phase_cnt_next = phase_cnt_reg - 4'd1;
        end
      end
      ST_WB: begin
        if (phase_cnt_reg == 4'd0) begin
          state_next    = ST_WAITRB;
          wait_cnt_next = WAIT_LOAD;
        end else begin
          phase_cnt_next = phase_cnt_reg - 4'd1;
        end
      end
      ST_WAITRB: begin
        // Ready wins over timeout on the last allowed cycle.
        if (F_RB) begin
          state_next     = ST_IDLE;
          rsp_valid_next = 1'b1;
        end else if (wait_cnt_reg == 16'd0) begin
          state_next     = ST_IDLE;
          rsp_valid_next = 1'b1;
          rsp_err_next   = 1'b1;
        end else begin
          wait_cnt_next = wait_cnt_reg - 16'd1;
        end
      end
      default: state_next = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_reg     <= ST_IDLE;
      op_reg        <= OP_CMD;
      data_reg      <= 8'h00;
      phase_cnt_reg <= 4'd0;
      wait_cnt_reg  <= 16'd0;
      rsp_valid_reg <= 1'b0;
      rsp_err_reg   <= 1'b0;
      rsp_data_reg  <= 8'h00;
    end else begin
      state_reg     <= state_next;
      op_reg        <= op_next;
      data_reg      <= data_next;
      phase_cnt_reg <= phase_cnt_next;
      wait_cnt_reg  <= wait_cnt_next;
      rsp_valid_reg <= rsp_valid_next;
      rsp_err_reg   <= rsp_err_next;
      rsp_data_reg  <= rsp_data_next;
    end
  end

  logic bus_phase;
  logic strobe_phase;
  logic io_drive;

  assign bus_phase    = (state_reg == ST_SETUP) || (state_reg == ST_PULSE) || (state_reg == ST_HOLD);
  assign strobe_phase = (state_reg == ST_PULSE);
  assign io_drive     = bus_phase && (op_reg != OP_READ);

  assign req_ready = (state_reg == ST_IDLE);
  assign rsp_valid = rsp_valid_reg;
  assign rsp_err   = rsp_err_reg;
  assign rsp_data  = rsp_data_reg;

  assign F_CLE   = bus_phase && (op_reg == OP_CMD);
  assign F_ALE   = bus_phase && (op_reg == OP_ADDR);
  assign F_WEN   = !(strobe_phase && (op_reg != OP_READ));
  assign F_REN   = !(strobe_phase && (op_reg == OP_READ));
  assign F_IO_oe = io_drive;

  genvar gi;
  generate
    for (gi = 0; gi < 8; gi++) begin : g_io_out
      assign F_IO_out[gi] = io_drive & data_reg[gi];
    end
  endgenerate

endmodule

// File: tb/tb_nand_bus_sequencer.sv
// Directed bench for nand_bus_sequencer: waveform checks per cycle plus a
// response scoreboard per instance (defaults, and TIMEOUT=8).
module tb_nand_bus_sequencer;

  localparam int TS   = 1;
  localparam int TP   = 2;
  localparam int TH   = 1;
  localparam int LAST = 1 + TS + TP + TH;

  typedef struct packed {
    logic       err;
    logic [7:0] data;
  } rsp_t;

  logic       clk = 1'b0;
  logic       rst;
  logic       req_valid, req_valid_b;
  logic [2:0] req_op;
  logic [7:0] req_data;
  logic       F_RB;
  logic [7:0] F_IO_in;

  logic       req_ready, rsp_valid, rsp_err, F_CLE, F_ALE, F_WEN, F_REN, F_IO_oe;
  logic [7:0] rsp_data, F_IO_out;
  logic       req_ready_b, rsp_valid_b, rsp_err_b, F_CLE_b, F_ALE_b, F_WEN_b, F_REN_b, F_IO_oe_b;
  logic [7:0] rsp_data_b, F_IO_out_b;

  int   total = 0;
  int   bad = 0;
  logic [7:0] exp_rdata;
  rsp_t sb_a[$];
  rsp_t sb_b[$];

  always #5 clk = ~clk;

  nand_bus_sequencer dut (
    .clk(clk), .rst(rst), .req_valid(req_valid), .req_ready(req_ready),
    .req_op(req_op), .req_data(req_data), .rsp_valid(rsp_valid),
    .rsp_data(rsp_data), .rsp_err(rsp_err), .F_CLE(F_CLE), .F_ALE(F_ALE),
    .F_WEN(F_WEN), .F_REN(F_REN), .F_RB(F_RB), .F_IO_out(F_IO_out),
    .F_IO_oe(F_IO_oe), .F_IO_in(F_IO_in)
  );

  nand_bus_sequencer #(.TIMEOUT(8)) dut_b (
    .clk(clk), .rst(rst), .req_valid(req_valid_b), .req_ready(req_ready_b),
    .req_op(req_op), .req_data(req_data), .rsp_valid(rsp_valid_b),
    .rsp_data(rsp_data_b), .rsp_err(rsp_err_b), .F_CLE(F_CLE_b), .F_ALE(F_ALE_b),
    .F_WEN(F_WEN_b), .F_REN(F_REN_b), .F_RB(F_RB), .F_IO_out(F_IO_out_b),
    .F_IO_oe(F_IO_oe_b), .F_IO_in(F_IO_in)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic next_cycle();
    @(posedge clk);
    #1;
  endtask

  task automatic check_idle_bus(input string tag);
    chk({tag, "_cle"}, 32'(F_CLE), 32'd0);
    chk({tag, "_ale"}, 32'(F_ALE), 32'd0);
    chk({tag, "_wen"}, 32'(F_WEN), 32'd1);
    chk({tag, "_ren"}, 32'(F_REN), 32'd1);
    chk({tag, "_oe"}, 32'(F_IO_oe), 32'd0);
    chk({tag, "_io"}, 32'(F_IO_out), 32'd0);
  endtask

  // Issues a CMD/ADDR/WRITE/READ in the current cycle and checks cycles 1..LAST.
  // Returns positioned in cycle LAST so the next op can be accepted back-to-back.
  task automatic bus_op(input logic [2:0] op, input logic [7:0] d, input logic [7:0] rd);
    req_valid = 1'b1;
    req_op    = op;
    req_data  = d;
    F_IO_in   = 8'h5A;
    chk("accept_ready", 32'(req_ready), 32'd1);
    if (op == 3'd3) begin
      exp_rdata = rd;
      sb_a.push_back({1'b0, rd});
    end
    next_cycle();
    req_valid = 1'b0;
    req_data  = 8'hFF;
    for (int c = 1; c <= LAST; c++) begin
      logic in_bus, in_pulse, drv;
      in_bus   = (c <= TS + TP + TH);
      in_pulse = (c > TS) && (c <= TS + TP);
      drv      = in_bus && (op != 3'd3);
      F_IO_in  = (c == TS + TP) ? rd : 8'h5A;
      chk($sformatf("op%0d_cle_c%0d", op, c), 32'(F_CLE), 32'(in_bus && op == 3'd0));
      chk($sformatf("op%0d_ale_c%0d", op, c), 32'(F_ALE), 32'(in_bus && op == 3'd1));
      chk($sformatf("op%0d_oe_c%0d", op, c), 32'(F_IO_oe), 32'(drv));
      chk($sformatf("op%0d_io_c%0d", op, c), 32'(F_IO_out), drv ? 32'(d) : 32'd0);
      chk($sformatf("op%0d_wen_c%0d", op, c), 32'(F_WEN), 32'(!(in_pulse && op != 3'd3)));
      chk($sformatf("op%0d_ren_c%0d", op, c), 32'(F_REN), 32'(!(in_pulse && op == 3'd3)));
      chk($sformatf("op%0d_ready_c%0d", op, c), 32'(req_ready), 32'(c == LAST));
      chk($sformatf("op%0d_rspv_c%0d", op, c), 32'(rsp_valid), 32'(c == LAST && op == 3'd3));
      if (c == LAST) chk($sformatf("op%0d_rdata", op), 32'(rsp_data), 32'(exp_rdata));
      if (c < LAST) next_cycle();
    end
  endtask

  always @(negedge clk) begin
    if (rsp_valid) begin
      chk("a_rsp_queued", 32'(sb_a.size() > 0), 32'd1);
      if (sb_a.size() > 0) begin
        rsp_t e;
        e = sb_a.pop_front();
        chk("a_rsp_err", 32'(rsp_err), 32'(e.err));
        chk("a_rsp_data", 32'(rsp_data), 32'(e.data));
      end
    end
    if (rsp_valid_b) begin
      chk("b_rsp_queued", 32'(sb_b.size() > 0), 32'd1);
      if (sb_b.size() > 0) begin
        rsp_t e;
        e = sb_b.pop_front();
        chk("b_rsp_err", 32'(rsp_err_b), 32'(e.err));
        chk("b_rsp_data", 32'(rsp_data_b), 32'(e.data));
      end
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog expired observed=running expected=finished");
    $fatal(1, "watchdog");
  end

  initial begin
    rst = 1'b1; req_valid = 1'b0; req_valid_b = 1'b0;
    req_op = 3'd0; req_data = 8'h00; F_RB = 1'b1; F_IO_in = 8'h00;
    exp_rdata = 8'h00;
    repeat (3) next_cycle();
    rst = 1'b0;

    // Reset state
    check_idle_bus("rst");
    chk("rst_rspv", 32'(rsp_valid), 32'd0);
    chk("rst_rdata", 32'(rsp_data), 32'd0);
    chk("rst_err", 32'(rsp_err), 32'd0);
    chk("rst_ready", 32'(req_ready), 32'd1);
    chk("rst_ready_b", 32'(req_ready_b), 32'd1);

    // CMD, READ, then WRITE which must leave rsp_data alone
    bus_op(3'd0, 8'h80, 8'h00);
    bus_op(3'd3, 8'h00, 8'hA5);
    bus_op(3'd2, 8'h3C, 8'h00);

    // WAIT_RB with a ready glitch during the blanking window
    req_valid = 1'b1; req_op = 3'd4; F_RB = 1'b0;
    chk("wrb_accept_ready", 32'(req_ready), 32'd1);
    sb_a.push_back({1'b0, exp_rdata});
    next_cycle();
    req_valid = 1'b0;
    for (int c = 1; c <= 12; c++) begin
      F_RB = (c == 1) || (c >= 11);
      check_idle_bus($sformatf("wrb_c%0d", c));
      chk($sformatf("wrb_rspv_c%0d", c), 32'(rsp_valid), 32'(c == 12));
      chk($sformatf("wrb_ready_c%0d", c), 32'(req_ready), 32'(c == 12));
      if (c == 12) chk("wrb_err", 32'(rsp_err), 32'd0);
      if (c < 12) next_cycle();
    end

    // Illegal op accepted back-to-back with the WAIT_RB completion
    req_valid = 1'b1; req_op = 3'd6; F_RB = 1'b1;
    sb_a.push_back({1'b1, exp_rdata});
    next_cycle();
    req_valid = 1'b0;
    chk("ill_rspv", 32'(rsp_valid), 32'd1);
    chk("ill_err", 32'(rsp_err), 32'd1);
    chk("ill_ready", 32'(req_ready), 32'd1);
    chk("ill_rdata", 32'(rsp_data), 32'hA5);
    check_idle_bus("ill");
    next_cycle();
    chk("ill_after_rspv", 32'(rsp_valid), 32'd0);
    chk("ill_after_err", 32'(rsp_err), 32'd0);
    check_idle_bus("ill_after");

    // Timeout on the TIMEOUT=8 instance: 2 blanking + 8 waiting cycles
    req_valid_b = 1'b1; req_op = 3'd4; F_RB = 1'b0;
    chk("to_accept_ready", 32'(req_ready_b), 32'd1);
    sb_b.push_back({1'b1, 8'h00});
    next_cycle();
    req_valid_b = 1'b0;
    for (int c = 1; c <= 11; c++) begin
      chk($sformatf("to_rspv_c%0d", c), 32'(rsp_valid_b), 32'(c == 11));
      chk($sformatf("to_ready_c%0d", c), 32'(req_ready_b), 32'(c == 11));
      chk($sformatf("to_wen_c%0d", c), 32'(F_WEN_b), 32'd1);
      chk($sformatf("to_oe_c%0d", c), 32'(F_IO_oe_b), 32'd0);
      if (c == 11) chk("to_err", 32'(rsp_err_b), 32'd1);
      if (c < 11) next_cycle();
    end

    // Ready seen on the last allowed waiting cycle is a success
    req_valid_b = 1'b1; req_op = 3'd4;
    sb_b.push_back({1'b0, 8'h00});
    next_cycle();
    req_valid_b = 1'b0;
    for (int c = 1; c <= 11; c++) begin
      F_RB = (c == 10);
      chk($sformatf("edge_rspv_c%0d", c), 32'(rsp_valid_b), 32'(c == 11));
      if (c == 11) chk("edge_err", 32'(rsp_err_b), 32'd0);
      if (c < 11) next_cycle();
    end
    F_RB = 1'b1;
    next_cycle();
    chk("edge_after_rspv", 32'(rsp_valid_b), 32'd0);

    // Reset during the strobe of a WRITE
    req_valid = 1'b1; req_op = 3'd2; req_data = 8'h77;
    next_cycle();
    req_valid = 1'b0;
    next_cycle();
    chk("mid_wen_low", 32'(F_WEN), 32'd0);
    chk("mid_oe_high", 32'(F_IO_oe), 32'd1);
    rst = 1'b1;
    next_cycle();
    rst = 1'b0;
    exp_rdata = 8'h00;
    check_idle_bus("mid_rst");
    chk("mid_rst_ready", 32'(req_ready), 32'd1);
    chk("mid_rst_rspv", 32'(rsp_valid), 32'd0);
    chk("mid_rst_rdata", 32'(rsp_data), 32'd0);
    next_cycle();

    // Back-to-back ADDR bytes after reset
    bus_op(3'd1, 8'h00, 8'h00);
    bus_op(3'd1, 8'h12, 8'h00);
    next_cycle();
    chk("sb_a_drained", 32'(sb_a.size()), 32'd0);
    chk("sb_b_drained", 32'(sb_b.size()), 32'd0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/nand_bus_sequencer.md
Name: nand_bus_sequencer

Overview:
- Per-flash-port bus timing engine. Sits directly downstream of the page-copy controller; one instance per NAND flash port (A and B).
- Converts single-transaction requests (command latch, address latch, data write, data read, wait-ready) into properly timed CLE/ALE/WEN/REN/IO waveforms.
- Returns read data and completion status through a valid-only response.

Parameters:
- T_SETUP, 1: cycles CLE/ALE/IO are driven before the strobe falls (legal 1..15).
- T_PULSE, 2: cycles WEN/REN are held low (legal 1..15).
- T_HOLD, 1: cycles CLE/ALE/IO are held after the strobe rises (legal 1..15).
- T_WB, 2: cycles F_RB is ignored after a WAIT_RB op starts (legal 1..15).
- TIMEOUT, 1023: maximum WAITRB cycles before error (legal 1..65535).

Ports:
- clk  in  1  clock; all logic on the rising edge.
- rst  in  1  synchronous, active-high reset.
- req_valid  in  1  request present.
- req_ready  out  1  high only in IDLE; transfer occurs when req_valid && req_ready.
- req_op  in  3  000 CMD, 001 ADDR, 010 WRITE, 011 READ, 100 WAIT_RB, 101-111 illegal.
- req_data  in  8  byte for CMD/ADDR/WRITE; ignored otherwise.
- rsp_valid  out  1  one-cycle completion pulse for READ, WAIT_RB and illegal ops.
- rsp_data  out  8  captured read byte; holds until the next READ capture.
- rsp_err  out  1  qualified by rsp_valid: 1 = timeout or illegal op.
- F_CLE, F_ALE  out  1  flash latch enables.
- F_WEN, F_REN  out  1  flash strobes, active low.
- F_RB  in  1  flash ready/busy (1 = ready); sampled directly, no synchroniser.
- F_IO_out  out  8  byte driven to flash.
- F_IO_oe  out  1  output enable for F_IO_out.
- F_IO_in  in  8  byte from flash.

Behaviour:
- Reset (sync): state IDLE; outputs as follows.
  - F_CLE=0, F_ALE=0, F_WEN=1, F_REN=1, F_IO_oe=0, F_IO_out=0.
  - rsp_valid=0, rsp_data=0, rsp_err=0.
  - req_ready=1 in the first cycle after reset.
- Reset asserted mid-op: outputs take reset values on the next edge; the in-flight op is dropped and no rsp is issued.
- States: IDLE, SETUP, PULSE, HOLD, WB, WAITRB. One down-counter (4 bits) serves the phase timers; a separate 16-bit counter serves WAITRB.
- Accept: op and data are latched at the transfer edge. req_op/req_data are sampled only at transfer; requests made while req_ready=0 are ignored.
- CMD/ADDR/WRITE/READ sequence: IDLE -> SETUP(T_SETUP cycles) -> PULSE(T_PULSE) -> HOLD(T_HOLD) -> IDLE.
  - F_CLE=1 throughout SETUP/PULSE/HOLD for CMD only; F_ALE=1 for ADDR only.
  - F_IO_oe=1 and F_IO_out=latched byte for CMD/ADDR/WRITE during SETUP/PULSE/HOLD. For READ, F_IO_oe=0.
  - PULSE: F_WEN=0 for CMD/ADDR/WRITE; F_REN=0 for READ. Strobes are high in all other states.
  - READ: F_IO_in is captured into rsp_data on the edge ending the last PULSE cycle. rsp_valid=1, rsp_err=0 in the first IDLE cycle after HOLD.
  - Occupancy is 1+T_SETUP+T_PULSE+T_HOLD cycles from accept cycle to the next req_ready (5 with defaults). CMD/ADDR/WRITE issue no rsp.
- WAIT_RB sequence: IDLE -> WB(T_WB cycles, F_RB ignored) -> WAITRB.
  - In WAITRB, the first cycle with F_RB=1 -> IDLE, rsp_valid=1, rsp_err=0.
  - If TIMEOUT WAITRB cycles elapse with F_RB=0 -> IDLE, rsp_valid=1, rsp_err=1.
  - F_RB=1 on the TIMEOUT-th cycle counts as success.
  - All flash outputs stay at idle values throughout.
- Illegal op: accepted; the state remains IDLE with no bus activity. rsp_valid=1, rsp_err=1 in the next cycle, during which req_ready=1.
- rsp_valid and rsp_err are 0 in every cycle except the completion pulse. rsp_data is unchanged by non-READ ops.
- Phase counters load value-1 on state entry and transition at 0. No wrap-around is possible for legal parameters.

Test Plan:
- Reset, then CMD 0x80 accepted at cycle 0 (defaults) -> cycles 1-4: F_CLE=1, F_IO_oe=1, F_IO_out=0x80. F_WEN=0 in cycles 2-3 only. Cycle 5: req_ready=1, no rsp_valid.
- READ with F_IO_in=0xA5 during PULSE -> F_REN=0 cycles 2-3, F_IO_oe=0. Cycle 5: rsp_valid=1, rsp_data=0xA5, rsp_err=0. rsp_data stays 0xA5 after a following WRITE 0x3C.
- WAIT_RB with F_RB=0 for 10 cycles then 1 -> F_RB glitch to 1 during WB ignored; rsp_valid=1, rsp_err=0 the cycle after F_RB=1 is seen in WAITRB.
- WAIT_RB with TIMEOUT=8 and F_RB held 0 -> rsp_valid=1, rsp_err=1 after 2+8 cycles; then IDLE.
- req_op=110 -> next cycle rsp_valid=1, rsp_err=1. All flash outputs remain idle; req_ready stays 1.
- rst=1 during PULSE of a WRITE -> next cycle F_WEN=1, F_IO_oe=0, state IDLE, no rsp_valid. A back-to-back ADDR 0x00/0x12 after reset both complete normally.
